// File: rtl/reg_dump_pkg.sv
// Shared constants and state encoding for the pipeline register dump sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } dump_state_t;

    localparam logic [7:0] HEADER_DEF    = 8'hA5;
    localparam int         PAYLOAD_BYTES = 36;
    localparam int         FRAME_BYTES   = 38;
    localparam int         IDX_W         = 6;

    // Frame byte index of the first (most significant) byte of each segment.
    localparam int OFF_ID_EX   = 1;
    localparam int OFF_EX_MEM  = 19;
    localparam int OFF_MEM_WB  = 23;
    localparam int OFF_WB_ID   = 29;
    localparam int OFF_CONTROL = 34;
    localparam int OFF_CSUM    = 37;

endpackage

// File: rtl/tx_watchdog.sv
// Per-byte watchdog: counts enabled cycles, flags the cycle the count reaches the limit.
// Latency: tc is combinational on the cycle the TIMEOUT_CYCLES-th enabled cycle is active.
// Backpressure: none; clr has priority over counting, counter saturates at the limit.
module tx_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count enabled cycles; hold at terminal count until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Streams a frozen snapshot of the pipeline registers to the UART TX as HEADER, payload, XOR checksum.
// Latency: first tx_start the cycle after the request is accepted; one byte per tx_start/txDone pair.
// Backpressure: waits on i_txDone per byte; aborts with o_error when the watchdog expires.
module reg_dump_sequencer
    import reg_dump_pkg::*;
#(
    parameter int          NB_DATA        = 8,
    parameter int          NB_ID_EX       = 144,
    parameter int          NB_EX_MEM      = 32,
    parameter int          NB_MEM_WB      = 48,
    parameter int          NB_WB_ID       = 40,
    parameter int          NB_CONTROL     = 24,
    parameter logic [7:0]  HEADER         = HEADER_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_dump_req,
    input  logic [NB_ID_EX-1:0]   i_segment_registers_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_segment_registers_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_segment_registers_MEM_WB,
    input  logic [NB_WB_ID-1:0]   i_segment_registers_WB_ID,
    input  logic [NB_CONTROL-1:0] i_control_registers_ID_EX,
    input  logic                  i_txDone,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int SNAP_W  = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int PAYLOAD = SNAP_W / NB_DATA;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD + 1);

    logic                rst_meta;
    logic                rst_n;
    dump_state_t         state;
    dump_state_t         state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [NB_DATA-1:0]  checksum;
    logic [SNAP_W-1:0]   snapshot;
    logic [NB_DATA-1:0]  pay_byte;
    logic [NB_DATA-1:0]  frame_byte;
    logic                wd_tc;

    // Reset asserts immediately, releases two clocks after i_rst_n rises.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; txDone is checked before the watchdog so a coincident txDone wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_dump_req) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT: begin
                if (i_txDone) begin
                    state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
                end else if (wd_tc) begin
                    state_nxt = ABORT;
                end
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture, byte index advance and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot <= '0;
            idx      <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_dump_req) begin
                        snapshot <= {i_segment_registers_ID_EX, i_segment_registers_EX_MEM,
                                     i_segment_registers_MEM_WB, i_segment_registers_WB_ID,
                                     i_control_registers_ID_EX};
                        idx      <= '0;
                        checksum <= '0;
                    end
                end
                LOAD: begin
                    if (idx != '0 && idx != LAST_IDX) begin
                        checksum <= checksum ^ pay_byte;
                    end
                end
                WAIT: begin
                    if (i_txDone && idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    // Payload byte mux: index 1 is the MSB byte of the snapshot.
    always_comb begin
        pay_byte = '0;
        for (int p = 1; p <= PAYLOAD; p++) begin
            if (idx == IDX_W'(p)) begin
                pay_byte = snapshot[SNAP_W - NB_DATA*p +: NB_DATA];
            end
        end
    end

    // Frame byte: header, payload or completed checksum.
    always_comb begin
        frame_byte = pay_byte;
        if (idx == '0) begin
            frame_byte = HEADER;
        end else if (idx == LAST_IDX) begin
            frame_byte = checksum;
        end
    end

    tx_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tx_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == LOAD),
        .en    (state == WAIT),
        .tc    (wd_tc)
    );

    // Outputs decode from state so they drop as soon as reset asserts.
    assign o_tx_start = (state == LOAD);
    assign o_busy     = (state == LOAD) || (state == WAIT);
    assign o_done     = (state == DONE);
    assign o_error    = (state == ABORT);
    assign o_data     = o_busy ? frame_byte : '0;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: directed scenarios with random snapshots.
// Latency: n/a.
// Backpressure: bench answers each tx_start with txDone 10 cycles later unless withholding.
module tb_reg_dump_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dump_req;
    logic [143:0] id_ex;
    logic [31:0]  ex_mem;
    logic [47:0]  mem_wb;
    logic [39:0]  wb_id;
    logic [23:0]  ctrl;
    logic         tx_done;
    logic         tx_start;
    logic [7:0]   data;
    logic         busy;
    logic         done;
    logic         error;

    int tests = 0;
    int fails = 0;

    logic [7:0] got[$];
    logic [7:0] exp_frame[38];
    int   done_cnt;
    int   err_cnt;
    int   err_gap;
    int   last_start;
    logic err_busy;
    logic data_unstable;
    logic frame_end_seen;
    logic reset_done;

    always #5 clk = ~clk;

    reg_dump_sequencer #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                        (clk),
        .i_rst_n                    (rst_n),
        .i_dump_req                 (dump_req),
        .i_segment_registers_ID_EX  (id_ex),
        .i_segment_registers_EX_MEM (ex_mem),
        .i_segment_registers_MEM_WB (mem_wb),
        .i_segment_registers_WB_ID  (wb_id),
        .i_control_registers_ID_EX  (ctrl),
        .i_txDone                   (tx_done),
        .o_tx_start                 (tx_start),
        .o_data                     (data),
        .o_busy                     (busy),
        .o_done                     (done),
        .o_error                    (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, segment bytes MSB first in segment order, XOR of payload.
    task automatic build_expected();
        logic [287:0] bits;
        logic [7:0]   cs;
        bits = {id_ex, ex_mem, mem_wb, wb_id, ctrl};
        cs   = 8'h00;
        exp_frame[0] = 8'hA5;
        for (int p = 1; p <= 36; p++) begin
            exp_frame[p] = bits[287:280];
            cs   = cs ^ bits[287:280];
            bits = bits << 8;
        end
        exp_frame[37] = cs;
    endtask

    task automatic randomize_inputs();
        id_ex  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
        ex_mem = $urandom();
        mem_wb = {$urandom(), 16'($urandom())};
        wb_id  = {$urandom(), 8'($urandom())};
        ctrl   = 24'($urandom());
    endtask

    // One request, then serve the frame until it ends (done/error) or a planted reset.
    task automatic run_frame(input int reset_at, input int req_at, input int withhold_after,
                             input bit scramble);
        int timer;
        int tail;
        int cyc;
        bit stop;
        got.delete();
        done_cnt = 0;
        err_cnt = 0;
        err_gap = -1;
        err_busy = 1'b1;
        data_unstable = 1'b0;
        frame_end_seen = 1'b0;
        reset_done = 1'b0;
        build_expected();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        if (scramble) begin
            id_ex  = '1;
            ex_mem = '1;
            mem_wb = '1;
            wb_id  = '1;
            ctrl   = '1;
        end
        timer = 0;
        tail  = 0;
        stop  = 1'b0;
        cyc   = 0;
        while (!stop && cyc < 3000) begin
            dump_req = 1'b0;
            tx_done  = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) tx_done = 1'b1;
            end
            if (tx_start) begin
                got.push_back(data);
                last_start = cyc;
                timer = (got.size() - 1 == withhold_after) ? 0 : 10;
                if (got.size() - 1 == req_at) dump_req = 1'b1;
                if (got.size() - 1 == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_midframe_outputs", {19'd0, tx_start, busy, done, error, data}, 32'd0);
                    tx_done = 1'b0;
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (5) @(negedge clk);
                    reset_done = 1'b1;
                    stop = 1'b1;
                end
            end else if (busy && got.size() > 0 && data !== got[got.size()-1]) begin
                data_unstable = 1'b1;
            end
            if (done) done_cnt++;
            if (error) begin
                err_cnt++;
                err_gap  = cyc - last_start;
                err_busy = busy;
            end
            if (done || error) frame_end_seen = 1'b1;
            if (frame_end_seen && !stop) begin
                tail++;
                if (tail > 5) stop = 1'b1;
            end
            if (!stop) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("frame_terminated", {31'd0, frame_end_seen || reset_done}, 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_len"}, got.size(), 38);
        for (int i = 0; i < 38 && i < got.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_frame[i]});
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_data_stable"}, {31'd0, data_unstable}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        dump_req = 1'b0;
        tx_done  = 1'b0;
        id_ex    = '0;
        ex_mem   = '0;
        mem_wb   = '0;
        wb_id    = '0;
        ctrl     = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {19'd0, tx_start, busy, done, error, data}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_release", {19'd0, tx_start, busy, done, error, data}, 32'd0);

        // All-zero snapshot.
        run_frame(-1, -1, -1, 1'b0);
        check_frame("zeros");
        if (got.size() == 38) begin
            check("zeros_header", {24'd0, got[0]}, 32'h0000_00A5);
            check("zeros_csum", {24'd0, got[37]}, 32'h0000_0000);
        end

        // Known bytes at both payload ends.
        id_ex = {8'h12, 136'd0};
        ctrl  = 24'h000034;
        run_frame(-1, -1, -1, 1'b0);
        check_frame("ends");
        if (got.size() == 38) begin
            check("ends_byte1", {24'd0, got[1]}, 32'h12);
            check("ends_byte36", {24'd0, got[36]}, 32'h34);
            check("ends_csum", {24'd0, got[37]}, 32'h26);
        end

        // Random snapshots.
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            run_frame(-1, -1, -1, 1'b0);
            check_frame($sformatf("rand%0d", k));
        end

        // Inputs change right after acceptance: frame keeps the captured snapshot.
        randomize_inputs();
        run_frame(-1, -1, -1, 1'b1);
        check_frame("frozen");

        // Second request during the frame is ignored.
        randomize_inputs();
        run_frame(-1, 5, -1, 1'b0);
        check_frame("busy_req");

        // txDone withheld after byte 3: abort after the watchdog expires.
        randomize_inputs();
        run_frame(-1, -1, 3, 1'b0);
        check("timeout_bytes", got.size(), 4);
        check("timeout_err_cnt", err_cnt, 1);
        check("timeout_done_cnt", done_cnt, 0);
        check("timeout_busy", {31'd0, err_busy}, 32'd0);
        check("timeout_window", {31'd0, (err_gap >= 100 && err_gap <= 102)}, 32'd1);

        // Clean frame after an abort.
        randomize_inputs();
        run_frame(-1, -1, -1, 1'b0);
        check_frame("post_abort");

        // Reset during byte 20, then a clean frame.
        randomize_inputs();
        run_frame(20, -1, -1, 1'b0);
        check("reset_hit", {31'd0, reset_done}, 32'd1);
        check("reset_no_done", done_cnt, 0);
        randomize_inputs();
        run_frame(-1, -1, -1, 1'b0);
        check_frame("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
